// File: rtl/lda_pkg.sv
// Shared types and defaults for the LDA local-count updater.
package lda_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR,
        ST_WR_WAIT,
        ST_DONE
    } state_e;

    // Phase 0 removes the token from its old topic, phase 1 adds it to the new one.
    localparam logic PH_DEC = 1'b0;
    localparam logic PH_INC = 1'b1;

    localparam int DEF_NUM_TOPICS  = 100;
    localparam int DEF_ACK_TIMEOUT = 15;

endpackage

// File: rtl/lda_addr_gen.sv
// Maps (word, doc, topic) onto the four count-memory addresses; K is the row stride.
module lda_addr_gen
    import lda_pkg::*;
#(
    parameter int NUM_TOPICS = DEF_NUM_TOPICS
) (
    input  logic [31:0] word_i,
    input  logic [31:0] doc_i,
    input  logic [31:0] topic_i,
    output logic [31:0] nw_addr_o,
    output logic [31:0] nd_addr_o,
    output logic [31:0] nwsum_addr_o,
    output logic [31:0] ndsum_addr_o
);

    localparam logic [31:0] K = 32'(NUM_TOPICS);

    assign nw_addr_o    = word_i * K + topic_i;
    assign nd_addr_o    = doc_i * K + topic_i;
    assign nwsum_addr_o = topic_i;
    assign ndsum_addr_o = doc_i;

endmodule

// File: rtl/lda_count_updater.sv
// Read-modify-write initiator moving one token between topics in the nw/nd/nwsum/ndsum counts.
module lda_count_updater
    import lda_pkg::*;
#(
    parameter int NUM_TOPICS  = DEF_NUM_TOPICS,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_init,
    input  logic [31:0] i_word,
    input  logic [31:0] i_doc,
    input  logic [31:0] i_old_topic,
    input  logic [31:0] i_new_topic,
    output logic        o_done,
    output logic        o_read_req,
    output logic [31:0] o_nw_raddr,
    output logic [31:0] o_nd_raddr,
    output logic [31:0] o_nwsum_raddr,
    output logic [31:0] o_ndsum_raddr,
    input  logic [31:0] i_nw_rdata,
    input  logic [31:0] i_nd_rdata,
    input  logic [31:0] i_nwsum_rdata,
    input  logic [31:0] i_ndsum_rdata,
    input  logic        i_read_ack,
    output logic        o_wen,
    output logic [31:0] o_nw_waddr,
    output logic [31:0] o_nd_waddr,
    output logic [31:0] o_nwsum_waddr,
    output logic [31:0] o_ndsum_waddr,
    output logic [31:0] o_nw_wdata,
    output logic [31:0] o_nd_wdata,
    output logic [31:0] o_nwsum_wdata,
    output logic [31:0] o_ndsum_wdata,
    input  logic        i_write_ack,
    input  logic        i_err_clr,
    output logic        o_underflow_err,
    output logic        o_overflow_err,
    output logic        o_timeout_err
);

    localparam int              CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              phase_q, phase_d;
    logic [31:0]       word_q, word_d, doc_q, doc_d, old_q, old_d, new_q, new_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       nw_wd_q, nw_wd_d, nd_wd_q, nd_wd_d;
    logic [31:0]       nwsum_wd_q, nwsum_wd_d, ndsum_wd_q, ndsum_wd_d;
    logic              unf_q, unf_d, ovf_q, ovf_d, tmo_q, tmo_d;
    logic              unf_set, ovf_set, tmo_set;
    logic [31:0]       topic;
    logic [31:0]       nw_addr, nd_addr, nwsum_addr, ndsum_addr;

    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? 32'hFFFF_FFFF : v + 32'd1;
    endfunction

    assign topic = (phase_q == PH_INC) ? new_q : old_q;

    lda_addr_gen #(.NUM_TOPICS(NUM_TOPICS)) u_addr_gen (
        .word_i       (word_q),
        .doc_i        (doc_q),
        .topic_i      (topic),
        .nw_addr_o    (nw_addr),
        .nd_addr_o    (nd_addr),
        .nwsum_addr_o (nwsum_addr),
        .ndsum_addr_o (ndsum_addr)
    );

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        word_d     = word_q;
        doc_d      = doc_q;
        old_d      = old_q;
        new_d      = new_q;
        cnt_d      = cnt_q;
        nw_wd_d    = nw_wd_q;
        nd_wd_d    = nd_wd_q;
        nwsum_wd_d = nwsum_wd_q;
        ndsum_wd_d = ndsum_wd_q;
        unf_set    = 1'b0;
        ovf_set    = 1'b0;
        tmo_set    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    word_d = i_word;
                    doc_d  = i_doc;
                    old_d  = i_old_topic;
                    new_d  = i_new_topic;
                    if (i_cmd_init) begin
                        phase_d = PH_INC;
                        state_d = ST_RD_REQ;
                    end else if (i_old_topic == i_new_topic) begin
                        state_d = ST_DONE;
                    end else begin
                        phase_d = PH_DEC;
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                cnt_d   = '0;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (i_read_ack) begin
                    state_d    = ST_WR;
                    ndsum_wd_d = i_ndsum_rdata;
                    if (phase_q == PH_DEC) begin
                        nw_wd_d    = sat_dec(i_nw_rdata);
                        nd_wd_d    = sat_dec(i_nd_rdata);
                        nwsum_wd_d = sat_dec(i_nwsum_rdata);
                        unf_set    = (i_nw_rdata == 32'd0) | (i_nd_rdata == 32'd0) |
                                     (i_nwsum_rdata == 32'd0);
                    end else begin
                        nw_wd_d    = sat_inc(i_nw_rdata);
                        nd_wd_d    = sat_inc(i_nd_rdata);
                        nwsum_wd_d = sat_inc(i_nwsum_rdata);
                        ovf_set    = (&i_nw_rdata) | (&i_nd_rdata) | (&i_nwsum_rdata);
                    end
                end else if (cnt_q == CNT_LAST) begin
                    tmo_set = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WR: begin
                cnt_d   = '0;
                state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (i_write_ack) begin
                    if (phase_q == PH_DEC) begin
                        phase_d = PH_INC;
                        state_d = ST_RD_REQ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    tmo_set = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // A new error event outranks a simultaneous clear.
        unf_d = unf_set | (unf_q & ~i_err_clr);
        ovf_d = ovf_set | (ovf_q & ~i_err_clr);
        tmo_d = tmo_set | (tmo_q & ~i_err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_DEC;
            word_q     <= '0;
            doc_q      <= '0;
            old_q      <= '0;
            new_q      <= '0;
            cnt_q      <= '0;
            nw_wd_q    <= '0;
            nd_wd_q    <= '0;
            nwsum_wd_q <= '0;
            ndsum_wd_q <= '0;
            unf_q      <= 1'b0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            word_q     <= word_d;
            doc_q      <= doc_d;
            old_q      <= old_d;
            new_q      <= new_d;
            cnt_q      <= cnt_d;
            nw_wd_q    <= nw_wd_d;
            nd_wd_q    <= nd_wd_d;
            nwsum_wd_q <= nwsum_wd_d;
            ndsum_wd_q <= ndsum_wd_d;
            unf_q      <= unf_d;
            ovf_q      <= ovf_d;
            tmo_q      <= tmo_d;
        end
    end

    assign o_cmd_ready     = (state_q == ST_IDLE);
    assign o_read_req      = (state_q == ST_RD_REQ);
    assign o_wen           = (state_q == ST_WR);
    assign o_done          = (state_q == ST_DONE);
    assign o_nw_raddr      = nw_addr;
    assign o_nd_raddr      = nd_addr;
    assign o_nwsum_raddr   = nwsum_addr;
    assign o_ndsum_raddr   = ndsum_addr;
    assign o_nw_waddr      = nw_addr;
    assign o_nd_waddr      = nd_addr;
    assign o_nwsum_waddr   = nwsum_addr;
    assign o_ndsum_waddr   = ndsum_addr;
    assign o_nw_wdata      = nw_wd_q;
    assign o_nd_wdata      = nd_wd_q;
    assign o_nwsum_wdata   = nwsum_wd_q;
    assign o_ndsum_wdata   = ndsum_wd_q;
    assign o_underflow_err = unf_q;
    assign o_overflow_err  = ovf_q;
    assign o_timeout_err   = tmo_q;

endmodule

// File: doc/lda_count_updater.md
Name: lda_count_updater

Overview:
- Initiator side of the LDA local-count memory read/write protocol.
- Accepts one token-reassignment command: word w, doc d, old topic, new topic.
- Performs read-modify-write on the four count memories (nw, nd, nwsum, ndsum):
  - decrements counts for the old topic;
  - increments counts for the new topic.
- Sits between the Gibbs topic sampler and the local count memory.

Parameters:
- NUM_TOPICS, 100, K; topic index range 0..K-1, used as the row stride for nw and nd addresses.
- ACK_TIMEOUT, 15, maximum cycles to wait for a read or write ack before aborting.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  high only in IDLE
- i_cmd_init  in  1  1 = add-only: skip decrement phase (initial assignment)
- i_word, i_doc, i_old_topic, i_new_topic  in  32 each  command fields
- o_done  out  1  one-cycle completion pulse
- o_read_req  out  1  one-cycle read request pulse
- o_nw_raddr, o_nd_raddr, o_nwsum_raddr, o_ndsum_raddr  out  32 each  read addresses
- i_nw_rdata, i_nd_rdata, i_nwsum_rdata, i_ndsum_rdata  in  32 each  read data, valid only while i_read_ack=1
- i_read_ack  in  1  read data valid
- o_wen  out  1  one-cycle write strobe, writes all four memories
- o_nw_waddr, o_nd_waddr, o_nwsum_waddr, o_ndsum_waddr  out  32 each  write addresses
- o_nw_wdata, o_nd_wdata, o_nwsum_wdata, o_ndsum_wdata  out  32 each  write data
- i_write_ack  in  1  write acknowledged
- i_err_clr  in  1  clears sticky error flags
- o_underflow_err, o_overflow_err, o_timeout_err  out  1 each  sticky error flags

Behaviour:
- Reset:
  - state IDLE, all outputs 0 except o_cmd_ready=1;
  - reset mid-operation aborts immediately with no further req/wen; a partially updated memory is accepted.
- Accept: a command is captured when i_cmd_valid & o_cmd_ready.
- Phase selection:
  - old_topic==new_topic and i_cmd_init=0: no memory traffic, o_done pulses the next cycle.
  - i_cmd_init=1: phase 1 only.
  - otherwise: phase 0, then phase 1.
- Phase topic: phase 0 uses t=old_topic, phase 1 uses t=new_topic.
- Addresses, low 32 bits of the arithmetic:
  - nw = w*K + t
  - nd = d*K + t
  - nwsum = t
  - ndsum = d
  - Held stable from RD_REQ until the phase ends; waddr equals raddr.
- State flow:
  - IDLE -> RD_REQ:
    - RD_REQ asserts o_read_req for 1 cycle.
    - The memory returns i_read_ack 2 cycles after the request cycle.
  - RD_WAIT:
    - On i_read_ack, capture all four rdata and compute write data, then -> WR.
    - Phase 0: nw-1, nd-1, nwsum-1, ndsum unchanged.
    - Phase 1: nw+1, nd+1, nwsum+1, ndsum unchanged.
  - WR: o_wen for 1 cycle, then -> WR_WAIT.
  - WR_WAIT:
    - On i_write_ack (arrives 1 cycle after o_wen): phase 0 -> RD_REQ with phase 1; phase 1 -> DONE.
  - DONE: o_done for 1 cycle, then -> IDLE.
- Latency from accept cycle 0, each phase taking 5 cycles:
  - full update: o_done in cycle 11;
  - init: o_done in cycle 6;
  - same-topic: o_done in cycle 1.
- Saturation:
  - Decrement of 0 writes 0 and sets o_underflow_err.
  - Increment of 0xFFFFFFFF writes 0xFFFFFFFF and sets o_overflow_err.
- Timeout:
  - A counter runs in RD_WAIT/WR_WAIT and resets on entry.
  - If ACK_TIMEOUT cycles pass without an ack: set o_timeout_err, go to DONE (o_done still pulses), skip remaining phases.
- Error flags:
  - Sticky until i_err_clr or rst.
  - A set event in the same cycle as i_err_clr wins (flag stays 1).
- Ack handling: a stray i_read_ack/i_write_ack outside its wait state is ignored.

Decomposition:
- Package lda_pkg:
  - state enum (IDLE, RD_REQ, RD_WAIT, WR, WR_WAIT, DONE);
  - phase encoding;
  - default NUM_TOPICS and ACK_TIMEOUT constants.
- Sub-module lda_addr_gen: combinational, (w, d, t, K) -> four addresses.

Test Plan:
- Full update, K=100, memory preloaded nw[502]=4, nd[302]=1, nwsum[2]=10, ndsum[3]=20, nw[507]=0, nd[307]=0, nwsum[7]=6. Command w=5, d=3, old=2, new=7:
  - phase 0 writes (502,302,2,3) <- (3,0,9,20);
  - phase 1 writes (507,307,7,3) <- (1,1,7,20);
  - o_done in cycle 11, no error flags.
- Init command w=5, d=3, new=7 on the same memory: single read and single write (507,307,7,3) <- (1,1,7,20), o_done in cycle 6.
- Same topic old=new=4: no o_read_req or o_wen, o_done in cycle 1, memory unchanged.
- Underflow: nw[502]=0 with old=2:
  - writes 0 to nw[502], o_underflow_err=1;
  - the flag stays set across the next command and clears on i_err_clr.
- Timeout: memory model suppresses i_read_ack:
  - o_timeout_err=1 and o_done pulse after 15 wait cycles;
  - no o_wen issued;
  - o_cmd_ready=1 afterwards.
- Reset asserted during WR_WAIT of phase 0: all outputs drop to reset values immediately, o_cmd_ready=1, no phase-1 traffic after reset release.
